// File: rtl/fir_mac_filter_pkg.sv
// Shared types and constants for the serial-MAC FIR filter.
package filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } fir_state_t;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  function automatic int unsigned idx_width(input int unsigned taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_mac_filter_if.sv
// Sample-in, coefficient-write and result-out handshake bundle for fir_mac_filter.
interface fir_mac_filter_if #(
  parameter int unsigned TAPS = 16
);
  import filter_pkg::*;

  localparam int unsigned IDX_W = idx_width(TAPS);

  logic signed [15:0] i_sample;
  logic               i_sample_valid;
  logic               o_sample_ready;
  logic               i_coef_we;
  logic [IDX_W-1:0]   i_coef_addr;
  logic signed [15:0] i_coef_data;
  logic signed [15:0] o_result;
  logic               o_result_valid;
  logic               i_result_ready;

  modport master (
    output i_sample, i_sample_valid, i_coef_we, i_coef_addr, i_coef_data, i_result_ready,
    input  o_sample_ready, o_result, o_result_valid
  );

  modport slave (
    input  i_sample, i_sample_valid, i_coef_we, i_coef_addr, i_coef_data, i_result_ready,
    output o_sample_ready, o_result, o_result_valid
  );

endinterface

// File: rtl/fir_round_sat.sv
// Round-half-toward-+inf and saturate a wide accumulator to a 16-bit signed sample.
module fir_round_sat
  import filter_pkg::*;
#(
  parameter int unsigned ACC_W     = 36,
  parameter int unsigned COEF_FRAC = 15
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [15:0]      o_result
);

  logic signed [ACC_W:0] half;
  logic signed [ACC_W:0] biased;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    half                = '0;
    half[COEF_FRAC-1]   = 1'b1;
    biased              = (ACC_W+1)'(i_acc) + half;
    shifted             = biased >>> COEF_FRAC;
    // In range exactly when every bit above bit 15 matches the sign.
    if ((shifted[ACC_W:15] == '0) || (shifted[ACC_W:15] == '1)) begin
      o_result = shifted[15:0];
    end else if (shifted[ACC_W]) begin
      o_result = SAT_MIN;
    end else begin
      o_result = SAT_MAX;
    end
  end

endmodule

// File: rtl/fir_mac_filter.sv
// Serial-MAC FIR: one sample per handshake, TAPS MACs on a shared multiplier,
// then round/saturate and hold the result until the downstream accepts it.
module fir_mac_filter
  import filter_pkg::*;
#(
  parameter int unsigned TAPS      = 16,
  parameter int unsigned COEF_FRAC = 15
) (
  input logic             i_clk,
  input logic             i_rst_n,
  fir_mac_filter_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(TAPS);
  localparam int unsigned ACC_W = 32 + IDX_W;

  typedef logic signed [15:0] word_t;

  fir_state_t              state_q, state_d;
  word_t                   dline_q [TAPS];
  word_t                   dline_d [TAPS];
  word_t                   coef_q  [TAPS];
  word_t                   coef_d  [TAPS];
  logic [IDX_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]        base_q, base_d;
  logic [IDX_W-1:0]        k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  word_t                   result_q, result_d;
  logic                    result_valid_q, result_valid_d;

  logic [IDX_W-1:0]        rd_idx;
  logic signed [31:0]      product;
  word_t                   rounded;

  fir_round_sat #(
    .ACC_W     (ACC_W),
    .COEF_FRAC (COEF_FRAC)
  ) u_round_sat (
    .i_acc    (acc_q),
    .o_result (rounded)
  );

  always_comb begin
    state_d        = state_q;
    dline_d        = dline_q;
    coef_d         = coef_q;
    wr_ptr_d       = wr_ptr_q;
    base_d         = base_q;
    k_d            = k_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;

    // Newest sample sits at base; tap k walks backwards through the circular line.
    rd_idx  = base_q - k_q;
    product = 32'(dline_q[rd_idx]) * 32'(coef_q[k_q]);

    case (state_q)
      IDLE: begin
        if (bus.i_coef_we) begin
          coef_d[bus.i_coef_addr] = bus.i_coef_data;
        end
        if (bus.i_sample_valid) begin
          dline_d[wr_ptr_q] = bus.i_sample;
          base_d            = wr_ptr_q;
          wr_ptr_d          = wr_ptr_q + IDX_W'(1);
          acc_d             = '0;
          k_d               = '0;
          state_d           = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(product);
        k_d   = k_q + IDX_W'(1);
        if (k_q == IDX_W'(TAPS - 1)) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d       = rounded;
        result_valid_d = 1'b1;
        state_d        = OUT;
      end
      OUT: begin
        if (bus.i_result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      dline_q        <= '{default: '0};
      coef_q         <= '{default: '0};
      wr_ptr_q       <= '0;
      base_q         <= '0;
      k_q            <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      dline_q        <= dline_d;
      coef_q         <= coef_d;
      wr_ptr_q       <= wr_ptr_d;
      base_q         <= base_d;
      k_q            <= k_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.o_sample_ready = (state_q == IDLE);
  assign bus.o_result       = result_q;
  assign bus.o_result_valid = result_valid_q;

endmodule
